mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data port. It accepts one load or store request at a time over a req/ready handshake and drives the word-organised `Memoria` block. Byte and halfword stores are performed as read-modify-write. Load data is extracted per lane and sign- or zero-extended. Misaligned accesses are answered with an error and never reach memory.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/lane_mux.sv | 44 ++++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: size codes, FSM states and
// the alignment rule.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StWrite,
      StResp
   } state_t;

   // Word needs offset 0, half needs an even offset, size 11 is always rejected.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_WORD: return off != 2'b00;
         SZ_HALF: return off[0];
         SZ_BYTE: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lane_mux.sv
// Little-endian byte-lane steering: extracts and extends a load lane, and
// merges store data into an old word for read-modify-write.
module lane_mux
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [15:0] wdata,
   output logic [31:0] ext,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = word[{offset, 3'b000} +: 8];
   assign lane_h = offset[1] ? word[31:16] : word[15:0];

   // Load path: pick the lane and extend it to 32 bits.
   always_comb begin
      ext = word;
      case (size)
         SZ_HALF: ext = {{16{sext & lane_h[15]}}, lane_h};
         SZ_BYTE: ext = {{24{sext & lane_b[7]}}, lane_b};
         default: ext = word;
      endcase
   end

   // Store path: replace only the addressed lane of the old word.
   always_comb begin
      merged = word;
      case (size)
         SZ_HALF: begin
            if (offset[1]) merged[31:16] = wdata;
            else           merged[15:0]  = wdata;
         end
         SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of a word-organised
// memory with one cycle of read latency.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_d, mem_din_d;
   logic              err_d, done_d;
   logic [31:0]       lane_ext, lane_merged;

   lane_mux u_lane_mux (
      .word   (mem_dout),
      .offset (addr_q[1:0]),
      .size   (size_q),
      .sext   (sext_q),
      .wdata  (wdata_q),
      .ext    (lane_ext),
      .merged (lane_merged)
   );

   assign ready    = (state_q == StIdle);
   assign mem_wr   = (state_q == StWrite) && !reset;
   assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      sext_d    = sext_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata;
      mem_din_d = mem_din;
      err_d     = err;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               addr_d  = addr;
               wdata_d = wdata[15:0];
               err_d   = 1'b0;
               if (is_misaligned(size, addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else if (we && size == SZ_WORD) begin
                  // Full-word store skips the read; data equals the latched wdata.
                  mem_din_d = wdata;
                  state_d   = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: state_d = StWait;
         StWait: begin
            if (we_q) begin
               mem_din_d = lane_merged;
               state_d   = StWrite;
            end else begin
               rdata_d = lane_ext;
               state_d = StResp;
            end
         end
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      done_d = (state_d == StResp);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= SZ_WORD;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         mem_din <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata   <= rdata_d;
         mem_din <= mem_din_d;
         err     <= err_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written handshake and
// reset-abort sequences, then random traffic against a byte-level model.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        ready, done, err, mem_wr;
   logic [31:0] rdata, mem_addr, mem_din;
   logic [31:0] mem_dout = '0;

   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:15];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          total = 0;
   int          bad = 0;

   mem_responder #(.ADDR_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .done     (done),
      .rdata    (rdata),
      .err      (err),
      .mem_addr (mem_addr),
      .mem_wr   (mem_wr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // Memory model: registered read, write on strobe.
   always @(posedge clk) begin
      mem_dout <= mem[mem_addr[7:2]];
      if (mem_wr) begin
         mem[mem_addr[7:2]] <= mem_din;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request from an idle negedge; return latency, err, rdata, writes.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int nwr);
      int w0;
      for (int k = 0; k < 10 && !ready; k++) @(negedge clk);
      w0 = wr_cnt;
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      e   = err;
      rd  = rdata;
      nwr = wr_cnt - w0;
   endtask

   // Reference: byte-wise view of memory, independent of any state machine.
   task automatic ref_apply(input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic e, output logic [31:0] rd,
                            output int nwr);
      int nb, off, idx;
      logic [31:0] mask, val, word;
      off = int'(a % 4);
      idx = int'(a / 4);
      nb  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      rd  = '0;
      nwr = 0;
      e   = (sz == 2'd3) || (off % nb != 0);
      if (e) begin
         lat = 1;
      end else if (!w) begin
         lat  = 3;
         mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
         val  = (ref_mem[idx] >> (8 * off)) & mask;
         if (sx && nb < 4 && val[8*nb-1]) val = val | ~mask;
         rd = val;
      end else begin
         lat  = (nb == 4) ? 2 : 4;
         nwr  = 1;
         word = ref_mem[idx];
         for (int b = 0; b < nb; b++) word[8*(off+b) +: 8] = d[8*b +: 8];
         ref_mem[idx] = word;
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int          lat, nwr, rlat, rnwr, accepts, first_acc, second_acc, dn, d0, w0;
      logic        e, re;
      logic [31:0] rd, rrd;

      vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2, 1,
                   32'hDEADBEEF};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 3, 0,
                   32'hDEADBEEF};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h11223344, 1'b0, 32'h0,        1'b0, 2, 1,
                   32'h11223344};
      vecs[3]  = '{1'b1, 2'b10, 1'b0, 32'h42, 32'h000000AA, 1'b0, 32'h0,        1'b0, 4, 1,
                   32'h11AA3344};
      vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h80FF7F01, 1'b0, 32'h0,        1'b0, 2, 1,
                   32'h80FF7F01};
      vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h42, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,        1'b1, 32'h000000FF, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h42, 32'h0,        1'b1, 32'hFFFF80FF, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h40, 32'h0,        1'b1, 32'h00007F01, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h41, 32'h0,        1'b0, 32'h0,        1'b1, 1, 0,
                   32'h80FF7F01};
      vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1'b1, 32'h80FF7F01, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h43, 32'h0000BEEF, 1'b0, 32'h0,        1'b1, 1, 0,
                   32'h80FF7F01};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1'b1, 32'h80FF7F01, 1'b0, 3, 0,
                   32'h80FF7F01};
      vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0,        1'b1, 1, 0,
                   32'h80FF7F01};
      vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234, 1'b0, 32'h0,        1'b0, 4, 1,
                   32'h12347F01};

      // Reset state.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ready",   {31'b0, ready},  32'd1);
      check("rst_done",    {31'b0, done},   32'd0);
      check("rst_rdata",   rdata,           32'd0);
      check("rst_err",     {31'b0, err},    32'd0);
      check("rst_mem_addr", mem_addr,       32'd0);
      check("rst_mem_wr",  {31'b0, mem_wr}, 32'd0);
      check("rst_mem_din", mem_din,         32'd0);
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 15; i++) begin
         do_req(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                lat, e, rd, nwr);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_wr", i),  nwr, vecs[i].exp_wr);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         @(negedge clk);
         check($sformatf("vec%0d_mem", i), mem[16], vecs[i].exp_mem);
      end

      // Hold req high across back-to-back loads: second accept only after RESP.
      accepts = 0; first_acc = -1; second_acc = -1; dn = 0;
      req = 1'b1; we = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h40;
      for (int i = 0; i < 8; i++) begin
         if (ready) begin
            accepts++;
            if (first_acc < 0) first_acc = i;
            else if (second_acc < 0) second_acc = i;
         end
         if (done) dn++;
         @(negedge clk);
      end
      req = 1'b0;
      check("hold_accepts", accepts, 2);
      check("hold_gap", second_acc - first_acc, 4);
      check("hold_dones", dn, 2);
      check("hold_rdata", rdata, 32'h12347F01);
      d0 = done_cnt;
      repeat (6) @(negedge clk);
      check("hold_no_queue", done_cnt - d0, 0);

      // Reset during WRITE of a byte store aborts the write and the done.
      w0 = wr_cnt; d0 = done_cnt;
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h41; wdata = 32'h00000055;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_din", mem_din, 32'h12345501);
      check("abort_wr_pre", {31'b0, mem_wr}, 32'd1);
      reset = 1'b1;
      #1 check("abort_wr_gated", {31'b0, mem_wr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_ready", {31'b0, ready}, 32'd1);
      check("abort_done", {31'b0, done}, 32'd0);
      repeat (4) @(negedge clk);
      check("abort_wr_cnt", wr_cnt - w0, 0);
      check("abort_done_cnt", done_cnt - d0, 0);
      check("abort_mem", mem[16], 32'h12347F01);

      // Random traffic against the reference model; fill memory first.
      for (int i = 0; i < 16; i++) begin
         rd = $urandom;
         ref_apply(1'b1, 2'b00, 1'b0, 32'(i * 4), rd, rlat, re, rrd, rnwr);
         do_req(1'b1, 2'b00, 1'b0, 32'(i * 4), rd, lat, e, rrd, nwr);
         check("fill_lat", lat, rlat);
      end
      for (int n = 0; n < 200; n++) begin
         logic        rw, rs;
         logic [1:0]  rsz;
         logic [31:0] ra, rwd;
         rw  = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 3));
         ra  = 32'($urandom_range(0, 63));
         rwd = $urandom;
         ref_apply(rw, rsz, rs, ra, rwd, rlat, re, rrd, rnwr);
         do_req(rw, rsz, rs, ra, rwd, lat, e, rd, nwr);
         check($sformatf("rnd%0d_lat", n), lat, rlat);
         check($sformatf("rnd%0d_err", n), {31'b0, e}, {31'b0, re});
         check($sformatf("rnd%0d_wr", n), nwr, rnwr);
         if (!rw && !re) check($sformatf("rnd%0d_rdata", n), rd, rrd);
      end
      @(negedge clk);
      for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
